// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and early-branch stall detection,
// taken-branch flush, memory freeze, and saturating stall/flush counters.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instrIFID,
  input  logic [31:0] instrIDEX,
  input  logic [31:0] instrEXMEM,
  input  logic        branch_taken,
  input  logic        ext_stall,
  input  logic        cnt_clr,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        hold_state,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  function automatic logic f_alu_r(input logic [31:0] i);
    return (i[31:26] == 6'd0) &&
      (i[5:0] inside {6'd4, 6'd32, 6'd34, 6'd36,
                      6'd37, 6'd38, 6'd42});
  endfunction

  function automatic logic f_alu_i(input logic [31:0] i);
    return i[31:26] inside {6'd8, 6'd10, 6'd12,
                            6'd13, 6'd14, 6'd15};
  endfunction

  function automatic logic f_lw(input logic [31:0] i);
    return i[31:26] == 6'd35;
  endfunction

  function automatic logic f_jr(input logic [31:0] i);
    return (i[31:26] == 6'd0) && (i[5:0] == 6'd8);
  endfunction

  function automatic logic [4:0] f_dst(input logic [31:0] i);
    if (f_alu_r(i))
      return i[15:11];
    if (f_alu_i(i) || f_lw(i))
      return i[20:16];
    return 5'd0;
  endfunction

  logic [4:0] w_id_rs;
  logic [4:0] w_id_rt;
  logic       w_rd_rs;
  logic       w_rd_rt;
  logic       w_early;
  logic [4:0] w_ex_dst;
  logic       w_ex_lw;
  logic       w_ex_alu;
  logic       w_rs_ex;
  logic       w_rt_ex;
  logic       w_rs_mem;
  logic       w_need1;
  logic       w_need2;
  logic       w_stall;
  logic       w_flush;

  assign w_id_rs = instrIFID[25:21];
  assign w_id_rt = instrIFID[20:16];
  assign w_early = (instrIFID[31:26] == 6'd7) || f_jr(instrIFID);
  assign w_rd_rt = f_alu_r(instrIFID) || (instrIFID[31:26] == 6'd43);
  assign w_rd_rs = w_rd_rt || w_early ||
                   f_alu_i(instrIFID) || f_lw(instrIFID);

  assign w_ex_dst = f_dst(instrIDEX);
  assign w_ex_lw  = f_lw(instrIDEX);
  assign w_ex_alu = f_alu_r(instrIDEX) || f_alu_i(instrIDEX);

  // Register 0 never matches: a zero source cannot carry a dependency.
  assign w_rs_ex  = w_rd_rs && (w_id_rs != 5'd0) && (w_id_rs == w_ex_dst);
  assign w_rt_ex  = w_rd_rt && (w_id_rt != 5'd0) && (w_id_rt == w_ex_dst);
  assign w_rs_mem = w_early && f_lw(instrEXMEM) && (w_id_rs != 5'd0) &&
                    (w_id_rs == instrEXMEM[20:16]);

  assign w_need2 = w_early && w_ex_lw && w_rs_ex;
  assign w_need1 = (w_ex_lw && (w_rs_ex || w_rt_ex)) ||
                   (w_early && w_ex_alu && w_rs_ex) || w_rs_mem;

  always_comb begin
    w_next      = r_state;
    w_stall     = 1'b0;
    w_flush     = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst || ext_stall) begin
      w_next = r_state;
    end else begin
      if (r_state == HOLD) begin
        w_stall = 1'b1;
        w_next  = RUN;
      end else if (w_need2) begin
        w_stall = 1'b1;
        w_next  = HOLD;
      end else if (w_need1) begin
        w_stall = 1'b1;
      end else begin
        w_flush = branch_taken;
      end
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      pc_en       = !w_stall;
      ifid_en     = !w_stall;
      idex_bubble = w_stall;
      ifid_flush  = w_flush;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= RUN;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else if (cnt_clr) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (w_stall && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_flush && (r_flush_cnt != 16'hFFFF))
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign hold_state   = (r_state == HOLD);
  assign stall_cycles = r_stall_cnt;
  assign flush_count  = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, directed corner sequences,
// and random traffic against a stall-count reference model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ifid = 32'd0;
  logic [31:0] idex = 32'd0;
  logic [31:0] exmem = 32'd0;
  logic        bt = 1'b0;
  logic        es = 1'b0;
  logic        clr = 1'b0;
  logic        pc_en, ifid_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_bubble, hold_state;
  logic [15:0] stall_cycles, flush_count;

  int nerr = 0;
  int nchk = 0;

  int m_pending = 0;
  int m_stall = 0;
  int m_flush = 0;

  localparam logic [6:0] O_RUN   = 7'b1111000;
  localparam logic [6:0] O_FLUSH = 7'b1111100;
  localparam logic [6:0] O_STALL = 7'b0011010;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .instrIFID(ifid), .instrIDEX(idex), .instrEXMEM(exmem),
    .branch_taken(bt), .ext_stall(es), .cnt_clr(clr),
    .pc_en(pc_en), .ifid_en(ifid_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .hold_state(hold_state),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {pc_en, ifid_en, exmem_en, memwb_en,
            ifid_flush, idex_bubble, hold_state};
  endfunction

  function automatic logic [31:0] enc_r(int fn, int rs, int rt, int rd);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rs, int rt);
    return {6'(op), 5'(rs), 5'(rt), 16'h0010};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stall cycles the rules demand for this instruction triple.
  function automatic int need(logic [31:0] f, logic [31:0] x,
                              logic [31:0] m);
    int fop = int'(f[31:26]);
    int ffn = int'(f[5:0]);
    int frs = int'(f[25:21]);
    int frt = int'(f[20:16]);
    int xop = int'(x[31:26]);
    int xfn = int'(x[5:0]);
    int xd = -1;
    bit [31:0] rmask = '0;
    bit ftype_r = (fop == 0) && (ffn inside {4, 32, 34, 36, 37, 38, 42});
    bit xtype_r = (xop == 0) && (xfn inside {4, 32, 34, 36, 37, 38, 42});
    bit early = (fop == 7) || (fop == 0 && ffn == 8);
    int n = 0;
    if (ftype_r || fop == 43)
      rmask = rmask | (32'd1 << frs) | (32'd1 << frt);
    if (fop inside {7, 8, 10, 12, 13, 14, 15, 35} || early)
      rmask = rmask | (32'd1 << frs);
    rmask[0] = 1'b0;
    if (xtype_r)
      xd = int'(x[15:11]);
    else if (xop inside {8, 10, 12, 13, 14, 15, 35})
      xd = int'(x[20:16]);
    if (xd == 0)
      xd = -1;
    if (xop == 35 && xd > 0 && rmask[xd])
      n = 1;
    if (early && xd > 0 && frs == xd)
      n = (xop == 35) ? 2 : (n > 1 ? n : 1);
    if (early && m[31:26] == 6'd35 && m[20:16] != 5'd0 &&
        int'(m[20:16]) == frs && n < 1)
      n = 1;
    return n;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    ifid = 32'd0; idex = 32'd0; exmem = 32'd0;
    bt = 1'b0; es = 1'b0; clr = 1'b0;
    #1;
    chk("rst_outs", 32'(outs()), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cycles), 32'd0);
    chk("rst_flush_cnt", 32'(flush_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_pending = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic t,
                      input logic e, input logic cl);
    logic [6:0] exp;
    int n;
    bit st;
    bit fl;
    ifid = a; idex = b; exmem = c; bt = t; es = e; clr = cl;
    n = 0; st = 0; fl = 0;
    if (!e) begin
      if (m_pending > 0)
        st = 1;
      else begin
        n = need(a, b, c);
        st = (n > 0);
        fl = !st && t;
      end
    end
    if (e)
      exp = 7'd0;
    else if (st)
      exp = O_STALL;
    else if (fl)
      exp = O_FLUSH;
    else
      exp = O_RUN;
    exp[0] = (m_pending > 0);
    #3;
    chk("outs", 32'(outs()), 32'(exp));
    chk("stall_cnt", 32'(stall_cycles), 32'(m_stall));
    chk("flush_cnt", 32'(flush_count), 32'(m_flush));
    @(posedge clk);
    if (!e) begin
      if (m_pending > 0)
        m_pending--;
      else if (n > 0)
        m_pending = n - 1;
    end
    if (cl) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (st && m_stall < 65535) m_stall++;
      if (fl && m_flush < 65535) m_flush++;
    end
    #1;
  endtask

  function automatic logic [31:0] rnd_instr();
    int rs = $urandom_range(0, 3);
    int rt = $urandom_range(0, 3);
    int rd = $urandom_range(0, 3);
    case ($urandom_range(0, 9))
      0: return enc_r(32, rs, rt, rd);
      1: return enc_r(42, rs, rt, rd);
      2: return enc_i(43, rs, rt);
      3: return enc_i(8, rs, rt);
      4: return enc_i(35, rs, rt);
      5: return enc_i(7, rs, rt);
      6: return enc_r(8, rs, 0, 0);
      7: return {6'd2, 26'($urandom)};
      8: return enc_i(13, rs, rt);
      default: return 32'd0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] f;
    logic [31:0] x;
    logic [31:0] m;
    logic        t;
    logic        e;
    logic [6:0]  exp;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [31:0] lw5, add5, lw9, bg9;
    lw5  = enc_i(35, 1, 5);
    add5 = enc_r(32, 5, 2, 3);
    lw9  = enc_i(35, 2, 9);
    bg9  = enc_i(7, 9, 0);

    tbl[0]  = '{32'd0, 32'd0, 32'd0, 1'b0, 1'b0, O_RUN};
    tbl[1]  = '{add5, lw5, 32'd0, 1'b0, 1'b0, O_STALL};
    tbl[2]  = '{enc_r(32, 0, 0, 3), enc_i(35, 1, 0), 32'd0,
                1'b0, 1'b0, O_RUN};
    tbl[3]  = '{{6'd2, 26'h55}, 32'd0, 32'd0, 1'b1, 1'b0, O_FLUSH};
    tbl[4]  = '{bg9, lw9, 32'd0, 1'b1, 1'b0, O_STALL};
    tbl[5]  = '{enc_r(8, 3, 0, 0), enc_i(8, 1, 3), 32'd0,
                1'b0, 1'b0, O_STALL};
    tbl[6]  = '{enc_i(7, 4, 0), 32'd0, enc_i(35, 1, 4),
                1'b0, 1'b0, O_STALL};
    tbl[7]  = '{enc_r(32, 4, 1, 2), 32'd0, enc_i(35, 1, 4),
                1'b0, 1'b0, O_RUN};
    tbl[8]  = '{enc_r(32, 6, 1, 2), enc_r(32, 1, 2, 6), 32'd0,
                1'b0, 1'b0, O_RUN};
    tbl[9]  = '{add5, lw5, 32'd0, 1'b1, 1'b1, 7'd0};
    tbl[10] = '{enc_i(43, 1, 7), enc_i(35, 2, 7), 32'd0,
                1'b0, 1'b0, O_STALL};
    tbl[11] = '{enc_i(2, 7, 7), enc_i(35, 2, 7), 32'd0,
                1'b1, 1'b0, O_FLUSH};
    tbl[12] = '{add5, enc_i(43, 1, 5), 32'd0, 1'b0, 1'b0, O_RUN};

    for (int i = 0; i < 13; i++) begin
      do_reset();
      ifid = tbl[i].f; idex = tbl[i].x; exmem = tbl[i].m;
      bt = tbl[i].t; es = tbl[i].e;
      #3;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end

    // load-use
    do_reset();
    step(add5, lw5, 32'd0, 0, 0, 0);
    chk("lu_cnt", 32'(stall_cycles), 32'd1);
    step(add5, 32'd0, lw5, 0, 0, 0);
    chk("lu_cnt_after", 32'(stall_cycles), 32'd1);

    // branch after load: two stall cycles
    do_reset();
    step(bg9, lw9, 32'd0, 0, 0, 0);
    chk("bl_hold", 32'(hold_state), 32'd1);
    step(bg9, 32'd0, lw9, 1, 0, 0);
    chk("bl_run", 32'(hold_state), 32'd0);
    chk("bl_cnt", 32'(stall_cycles), 32'd2);
    step(bg9, 32'd0, 32'd0, 1, 0, 0);
    chk("bl_flush_cnt", 32'(flush_count), 32'd1);

    // taken branch with and without a pending hazard
    do_reset();
    step({6'd2, 26'h40}, 32'd0, 32'd0, 1, 0, 0);
    chk("br_flush_cnt", 32'(flush_count), 32'd1);
    step(add5, lw5, 32'd0, 1, 0, 0);
    chk("br_haz_flush_cnt", 32'(flush_count), 32'd1);

    // freeze while in HOLD
    do_reset();
    step(bg9, lw9, 32'd0, 0, 0, 0);
    repeat (3) step(bg9, 32'd0, lw9, 1, 1, 0);
    chk("fz_hold", 32'(hold_state), 32'd1);
    chk("fz_cnt", 32'(stall_cycles), 32'd1);
    step(bg9, 32'd0, lw9, 0, 0, 0);
    chk("fz_rel_hold", 32'(hold_state), 32'd0);
    chk("fz_rel_cnt", 32'(stall_cycles), 32'd2);
    step(32'd0, 32'd0, 32'd0, 0, 0, 0);

    // register 0, saturation and clear
    do_reset();
    step(enc_r(32, 0, 0, 3), enc_i(35, 1, 0), 32'd0, 0, 0, 0);
    chk("r0_cnt", 32'(stall_cycles), 32'd0);
    ifid = add5; idex = lw5; exmem = 32'd0; bt = 0; es = 0; clr = 0;
    repeat (65535) @(posedge clk);
    #1;
    m_stall = 65535;
    chk("sat_full", 32'(stall_cycles), 32'hFFFF);
    step(add5, lw5, 32'd0, 0, 0, 0);
    chk("sat_hold", 32'(stall_cycles), 32'hFFFF);
    step(add5, lw5, 32'd0, 0, 0, 1);
    chk("clr_cnt", 32'(stall_cycles), 32'd0);

    // reset in the middle of HOLD
    do_reset();
    step(bg9, lw9, 32'd0, 0, 0, 0);
    step({6'd2, 26'h1}, 32'd0, 32'd0, 1, 0, 0);
    step(bg9, lw9, 32'd0, 0, 0, 0);
    chk("mh_hold", 32'(hold_state), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mh_outs", 32'(outs()), 32'd0);
    chk("mh_stall_cnt", 32'(stall_cycles), 32'd0);
    chk("mh_flush_cnt", 32'(flush_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_pending = 0; m_stall = 0; m_flush = 0;
    step(32'd0, 32'd0, 32'd0, 0, 0, 0);
    chk("mh_pc_en", 32'(pc_en), 32'd1);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++)
      step(rnd_instr(), rnd_instr(), rnd_instr(),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) < 3),
           ($urandom_range(0, 39) == 0));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: instrIFID  input  32  instruction word in IF/ID.
REQ-004 SHALL have port: instrIDEX  input  32  instruction word in ID/EX.
REQ-005 SHALL have port: instrEXMEM  input  32  instruction word in EX/MEM.
REQ-006 SHALL have port: branch_taken  input  1  ID-stage JUMP/BGTI/JR resolved as taken.
REQ-007 SHALL have port: ext_stall  input  1  memory busy; freezes whole pipeline.
REQ-008 SHALL have port: cnt_clr  input  1  synchronous clear of performance counters.
REQ-009 SHALL have ports: pc_en, ifid_en, exmem_en, memwb_en  output  1 each  register enables.
REQ-010 SHALL have ports: ifid_flush, idex_bubble  output  1 each  load NOP into IF/ID or ID/EX.
REQ-011 SHALL have port: hold_state  output  1  high while in HOLD state.
REQ-012 SHALL have ports: stall_cycles, flush_count  output  16 each  saturating counters.

Function
REQ-013 SHALL decode fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0].
REQ-014 SHALL treat as writers: op 0 with funct in {4,32,34,36,37,38,42} writing rd; op in {8,10,12,13,14,15,35} writing rt; register 0 SHALL never create a hazard.
REQ-015 SHALL treat ID readers as follows:
- ALU-R and SW: rs and rt.
- ALU-I, LW and BGTI(7): rs.
- op 0 funct 8 (JR): rs.
- JUMP(2) and NOP: none.
- Early consumers: BGTI and JR.
REQ-016 SHALL require 1 stall cycle (load-use) when IDEX is LW and its rt matches any ID source.
REQ-017 SHALL handle an ID early consumer as follows:
- IDEX ALU writer match: 1 stall cycle.
- IDEX LW match: 2 stall cycles.
- EXMEM LW match: 1 stall cycle.
- Otherwise: none.
REQ-018 SHALL implement the state machine as follows:
- States: RUN and HOLD.
- In RUN, a detected requirement stalls in the same cycle, combinationally.
- A 2-cycle requirement SHALL go RUN->HOLD; HOLD stalls unconditionally for one cycle, then goes HOLD->RUN.
- Hazard detection SHALL be ignored while in HOLD.
REQ-019 SHALL drive a stall cycle as: pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=1, memwb_en=1.
REQ-020 SHALL assert ifid_flush=1 in the cycle branch_taken=1 only when there is no stall and no ext_stall; branch_taken during a stall SHALL be ignored.
REQ-021 SHALL, while ext_stall=1:
- Drive all enables to 0 and ifid_flush=0, idex_bubble=0.
- Freeze the state; HOLD is not consumed.
- Count no stall cycle.
- ext_stall SHALL have priority over hazard stall, and hazard stall over flush.
REQ-022 SHALL drive, in a cycle with no stall and no flush: all enables=1, ifid_flush=0, idex_bubble=0.
REQ-023 SHALL increment stall_cycles once per hazard-stall cycle and flush_count once per ifid_flush cycle, each saturating at 16'hFFFF.
REQ-024 SHALL give cnt_clr priority over increment; the clearing cycle does not count.

Reset
REQ-025 SHALL, while rst=1, force state=RUN, both counters=0, all enables=0, ifid_flush=0 and idex_bubble=0, independent of clk.
REQ-026 SHALL, when rst asserts in HOLD, abandon the pending stall; after release, the first edge evaluates in RUN.

Verification
REQ-027 SHALL cover load-use: IDEX=LW rt=5, IFID=ADD rs=5 -> one cycle pc_en=0, idex_bubble=1, stall_cycles=1; next cycle (IDEX=NOP) all enables=1.
REQ-028 SHALL cover branch after load: IDEX=LW rt=9, IFID=BGTI rs=9 -> 2 stall cycles (RUN then HOLD), hold_state=1 in the second, stall_cycles=2.
REQ-029 SHALL cover taken branch with no hazard: IFID=JUMP, branch_taken=1 -> ifid_flush=1 for 1 cycle, flush_count=1; branch_taken with a pending hazard -> ifid_flush=0.
REQ-030 SHALL cover freeze: ext_stall=1 for 3 cycles while in HOLD -> all enables=0, state stays HOLD, stall_cycles unchanged; on release, one further stall cycle, then RUN.
REQ-031 SHALL cover register 0 and saturation:
- IDEX=LW rt=0, IFID=ADD rs=0 -> no stall.
- stall_cycles preloaded to 16'hFFFF by stimulus, then a further stall -> stays 16'hFFFF.
- cnt_clr=1 -> 0 next edge.
REQ-032 SHALL cover reset mid-HOLD: rst pulse -> immediately enables=0, counters=0; after release, the first cycle runs with pc_en=1.
